dbe_lz4_encoder: RTL and testbench

//   Token producer matching the LZ4 decoder: consumes a 13-bit symbol stream, emits 46-bit LITERAL/COPY_POINTER/MARKER tokens.

---
 rtl/dbe_lz4_pkg.sv | 64 ++++++
 rtl/dbe_lz4_encoder_if.sv | 15 +
 rtl/dbe_lz4_enc_hist.sv | 71 +++++++
 rtl/dbe_lz4_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_dbe_lz4_encoder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dbe_lz4_pkg.sv
// Package: dbe_lz4_pkg
// Shared definitions for the LZ4-style token stream: symbol/token widths,
// token kind encoding, encoder FSM states, token field positions and
// pack/unpack helpers. Also used by the decoder benches.
package dbe_lz4_pkg;

  localparam int DATA_W   = 13;
  localparam int TOKEN_W  = 46;

  // Token field positions
  localparam int KIND_LSB = 44;
  localparam int KIND_W   = 2;
  localparam int OFF_LSB  = 28;
  localparam int OFF_W    = 16;
  localparam int CNT_LSB  = 12;
  localparam int CNT_W    = 16;
  localparam int MARK_LSB = 8;
  localparam int MARK_W   = 4;
  localparam int LIT_LSB  = 0;
  localparam int LIT_W    = 8;

  localparam logic [3:0] MARK_END = 4'h1;

  typedef enum logic [1:0] {
    KIND_LIT  = 2'd0,
    KIND_COPY = 2'd1,
    KIND_MARK = 2'd2
  } tok_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MATCH  = 2'd1,
    ST_REPLAY = 2'd2
  } enc_state_e;

  function automatic logic [TOKEN_W-1:0] tok_pack(input tok_kind_e kind,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [CNT_W-1:0] cnt,
                                                  input logic [MARK_W-1:0] mark,
                                                  input logic [LIT_W-1:0] lit);
    return {kind, off, cnt, mark, lit};
  endfunction

  function automatic tok_kind_e tok_kind(input logic [TOKEN_W-1:0] t);
    return tok_kind_e'(t[KIND_LSB +: KIND_W]);
  endfunction

  function automatic logic [OFF_W-1:0] tok_off(input logic [TOKEN_W-1:0] t);
    return t[OFF_LSB +: OFF_W];
  endfunction

  function automatic logic [CNT_W-1:0] tok_cnt(input logic [TOKEN_W-1:0] t);
    return t[CNT_LSB +: CNT_W];
  endfunction

  function automatic logic [MARK_W-1:0] tok_mark(input logic [TOKEN_W-1:0] t);
    return t[MARK_LSB +: MARK_W];
  endfunction

  function automatic logic [LIT_W-1:0] tok_lit(input logic [TOKEN_W-1:0] t);
    return t[LIT_LSB +: LIT_W];
  endfunction

endpackage

// File: rtl/dbe_lz4_encoder_if.sv
// Interface: dbe_lz4_encoder_if
// Valid/ready stream bundle used for both the symbol input and token output.
//   data  W bits  payload
//   vld   1       payload valid (driven by master)
//   rdy   1       payload accepted when vld && rdy (driven by slave)
interface dbe_lz4_encoder_if #(
  parameter int W = 13
) ();
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/dbe_lz4_enc_hist.sv
// Module: dbe_lz4_enc_hist
// Byte history shift register with saturating fill count and a priority
// match finder (lowest distance wins).
//   clk, rst   clock, synchronous active-high reset
//   byte_in    byte shifted in on shift, and the byte searched for
//   shift      push byte_in into hist[0]
//   clear      empty the history (fill -> 0)
//   skip0      search from hist[1]; a hit at index i is distance i
//   q_dist     distance to read back (1..HIST_DEPTH)
//   hit/hit_dist  match found / its distance
//   q_byte     byte at distance q_dist; head = hist[0]
module dbe_lz4_enc_hist #(
  parameter int HIST_DEPTH = 16,
  localparam int DIST_W    = $clog2(HIST_DEPTH) + 1,
  localparam int IDX_W     = $clog2(HIST_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              shift,
  input  logic              clear,
  input  logic              skip0,
  input  logic [DIST_W-1:0] q_dist,
  output logic              hit,
  output logic [DIST_W-1:0] hit_dist,
  output logic [7:0]        q_byte,
  output logic [7:0]        head
);

  logic [7:0]        hist_r [HIST_DEPTH];
  logic [DIST_W-1:0] fill_r;
  logic              m_s;

  // History shift register and saturating fill counter
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_r <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_r[i] <= 8'h00;
    end else begin
      if (shift) begin
        hist_r[0] <= byte_in;
        for (int i = 1; i < HIST_DEPTH; i++) hist_r[i] <= hist_r[i-1];
      end else begin
        for (int i = 0; i < HIST_DEPTH; i++) hist_r[i] <= hist_r[i];
      end
      if (clear) begin
        fill_r <= '0;
      end else if (shift && (fill_r < DIST_W'(HIST_DEPTH))) begin
        fill_r <= fill_r + DIST_W'(1);
      end else begin
        fill_r <= fill_r;
      end
    end
  end

  // Priority finder: scan from the deepest entry so the lowest distance wins
  always_comb begin
    hit      = 1'b0;
    hit_dist = '0;
    m_s      = 1'b0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      m_s      = (DIST_W'(i) < fill_r) && !(skip0 && (i == 0)) && (hist_r[i] == byte_in);
      hit      = hit | m_s;
      hit_dist = m_s ? (skip0 ? DIST_W'(i) : DIST_W'(i + 1)) : hit_dist;
    end
  end

  assign q_byte = hist_r[IDX_W'(q_dist - DIST_W'(1))];
  assign head   = hist_r[0];

endmodule

// File: rtl/dbe_lz4_encoder.sv
// Module: dbe_lz4_encoder
// Greedy LZ4-style token producer: turns a 13-bit symbol stream into 46-bit
// LITERAL / COPY_POINTER / MARKER tokens using a small shift-register history.
//   clk, rst   single clock, synchronous active-high reset
//   i_data     slave stream, [12:9] mark, [8] is_marker, [7:0] byte
//   o_token    master stream, registered token slot (1 token/cycle max)
// Optional feature macro DBE_LZ4_ENC_STATS_EN adds o_stat_lit, o_stat_copy,
// o_stat_bytes handshake counters.
module dbe_lz4_encoder
  import dbe_lz4_pkg::*;
#(
  parameter int          HIST_DEPTH = 16,
  parameter logic [15:0] COUNT_MAX  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  dbe_lz4_encoder_if.slave    i_data,
  dbe_lz4_encoder_if.master   o_token
`ifdef DBE_LZ4_ENC_STATS_EN
  ,
  output logic [31:0]         o_stat_lit,
  output logic [31:0]         o_stat_copy,
  output logic [31:0]         o_stat_bytes
`endif
);

  localparam int DIST_W = $clog2(HIST_DEPTH) + 1;

  enc_state_e           state_r, state_nx_s;
  logic [DIST_W-1:0]    dist_r, dist_nx_s;
  logic [15:0]          cnt_r, cnt_nx_s;      // match length - 1
  logic [DATA_W-1:0]    rb_r, rb_nx_s;        // replay symbol (byte or marker)
  logic [TOKEN_W-1:0]   tok_r, tok_nx_s;
  logic                 vld_r;
  logic                 load_s, shift_s, clear_s, skip0_s;
  logic                 can_load_s, rdy_s, acc_s;
  logic [7:0]           hbyte_s, in_byte_s;
  logic [3:0]           in_mark_s;
  logic                 in_is_mk_s;
  logic                 hit_s;
  logic [DIST_W-1:0]    hit_dist_s;
  logic [7:0]           q_byte_s, head_s;

  assign in_byte_s  = i_data.data[7:0];
  assign in_is_mk_s = i_data.data[8];
  assign in_mark_s  = i_data.data[12:9];

  assign can_load_s = !vld_r || o_token.rdy;
  assign rdy_s      = !rst && (state_r != ST_REPLAY) && can_load_s;
  assign acc_s      = i_data.vld && rdy_s;
  // REPLAY searches for the replayed byte, which is already hist[0]
  assign skip0_s    = (state_r == ST_REPLAY);
  assign hbyte_s    = skip0_s ? rb_r[7:0] : in_byte_s;

  assign i_data.rdy   = rdy_s;
  assign o_token.vld  = vld_r;
  assign o_token.data = tok_r;

  dbe_lz4_enc_hist #(.HIST_DEPTH(HIST_DEPTH)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .byte_in  (hbyte_s),
    .shift    (shift_s),
    .clear    (clear_s),
    .skip0    (skip0_s),
    .q_dist   (dist_r),
    .hit      (hit_s),
    .hit_dist (hit_dist_s),
    .q_byte   (q_byte_s),
    .head     (head_s)
  );

  // Next-state, token and history control
  always_comb begin
    state_nx_s = state_r;
    dist_nx_s  = dist_r;
    cnt_nx_s   = cnt_r;
    rb_nx_s    = rb_r;
    tok_nx_s   = '0;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          if (in_is_mk_s) begin
            load_s   = 1'b1;
            tok_nx_s = tok_pack(KIND_MARK, 16'h0000, 16'h0000, in_mark_s, 8'h00);
            clear_s  = (in_mark_s == MARK_END);
          end else if (hit_s) begin
            state_nx_s = ST_MATCH;
            dist_nx_s  = hit_dist_s;
            cnt_nx_s   = 16'h0000;
            shift_s    = 1'b1;
          end else begin
            load_s   = 1'b1;
            tok_nx_s = tok_pack(KIND_LIT, 16'h0000, 16'h0000, 4'h0, in_byte_s);
            shift_s  = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MATCH: begin
        if (acc_s) begin
          if (!in_is_mk_s && (q_byte_s == in_byte_s) && (cnt_r < COUNT_MAX)) begin
            cnt_nx_s = cnt_r + 16'd1;
            shift_s  = 1'b1;
          end else begin
            // Break (mismatch, marker or full count): flush pending, replay symbol
            load_s = 1'b1;
            if (cnt_r == 16'h0000) begin
              tok_nx_s = tok_pack(KIND_LIT, 16'h0000, 16'h0000, 4'h0, head_s);
            end else begin
              tok_nx_s = tok_pack(KIND_COPY, 16'(dist_r) - 16'd1, cnt_r, 4'h0, 8'h00);
            end
            rb_nx_s    = i_data.data;
            shift_s    = !in_is_mk_s;
            state_nx_s = ST_REPLAY;
          end
        end else begin
          state_nx_s = ST_MATCH;
        end
      end
      ST_REPLAY: begin
        if (can_load_s) begin
          if (rb_r[8]) begin
            load_s     = 1'b1;
            tok_nx_s   = tok_pack(KIND_MARK, 16'h0000, 16'h0000, rb_r[12:9], 8'h00);
            clear_s    = (rb_r[12:9] == MARK_END);
            state_nx_s = ST_IDLE;
          end else if (hit_s) begin
            state_nx_s = ST_MATCH;
            dist_nx_s  = hit_dist_s;
            cnt_nx_s   = 16'h0000;
          end else begin
            load_s     = 1'b1;
            tok_nx_s   = tok_pack(KIND_LIT, 16'h0000, 16'h0000, 4'h0, rb_r[7:0]);
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_REPLAY;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, match tracking and replay register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      dist_r  <= '0;
      cnt_r   <= 16'h0000;
      rb_r    <= '0;
    end else begin
      state_r <= state_nx_s;
      dist_r  <= dist_nx_s;
      cnt_r   <= cnt_nx_s;
      rb_r    <= rb_nx_s;
    end
  end

  // Output token slot: refills on the same edge it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= 1'b0;
      tok_r <= '0;
    end else if (load_s) begin
      vld_r <= 1'b1;
      tok_r <= tok_nx_s;
    end else if (o_token.rdy) begin
      vld_r <= 1'b0;
      tok_r <= tok_r;
    end else begin
      vld_r <= vld_r;
      tok_r <= tok_r;
    end
  end

`ifdef DBE_LZ4_ENC_STATS_EN
  // Per-kind token handshake counters, wrapping mod 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_lit   <= 32'd0;
      o_stat_copy  <= 32'd0;
      o_stat_bytes <= 32'd0;
    end else if (vld_r && o_token.rdy) begin
      case (tok_kind(tok_r))
        KIND_LIT: begin
          o_stat_lit   <= o_stat_lit + 32'd1;
          o_stat_bytes <= o_stat_bytes + 32'd1;
        end
        KIND_COPY: begin
          o_stat_copy  <= o_stat_copy + 32'd1;
          o_stat_bytes <= o_stat_bytes + 32'(tok_cnt(tok_r)) + 32'd1;
        end
        default: begin
          o_stat_lit   <= o_stat_lit;
        end
      endcase
    end else begin
      o_stat_lit   <= o_stat_lit;
    end
  end
`endif

endmodule

// File: tb/tb_dbe_lz4_encoder.sv
// Directed bench for dbe_lz4_encoder: symbols are driven in a linear
// sequence, completed token handshakes are queued by a monitor and compared
// against hand-computed tokens.
module tb_dbe_lz4_encoder;

  logic clk = 1'b0;
  logic rst;

  dbe_lz4_encoder_if #(.W(13)) i_data ();
  dbe_lz4_encoder_if #(.W(46)) o_token ();

`ifdef DBE_LZ4_ENC_STATS_EN
  logic [31:0] st_lit, st_copy, st_bytes;
`endif

  dbe_lz4_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .o_token (o_token)
`ifdef DBE_LZ4_ENC_STATS_EN
    ,
    .o_stat_lit   (st_lit),
    .o_stat_copy  (st_copy),
    .o_stat_bytes (st_bytes)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int rdy_drops   = 0;
  bit watch_rdy   = 1'b0;
  logic [45:0] got_q [$];

  // Capture every token handshake (values are stable from negedge to posedge)
  always @(negedge clk) begin
    if (o_token.vld && o_token.rdy) got_q.push_back(o_token.data);
  end

  // Count input-ready drops while the consumer is ready
  always @(negedge clk) begin
    if (watch_rdy && o_token.rdy && !i_data.rdy) rdy_drops++;
  end

  function automatic logic [45:0] tk(input logic [1:0] k, input logic [15:0] off,
                                     input logic [15:0] cnt, input logic [3:0] mk,
                                     input logic [7:0] lit);
    tk = {k, off, cnt, mk, lit};
  endfunction

  function automatic logic [12:0] sb(input logic [7:0] b);
    sb = {4'h0, 1'b0, b};
  endfunction

  localparam logic [12:0] SYM_END = {4'h1, 1'b1, 8'h00};

  task automatic chk(input string tag, input logic [45:0] obs, input logic [45:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input string tag);
    bit ok = 1'b0;
    int n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (i_data.rdy) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
      n++;
    end
    i_data.vld = 1'b0;
    if (!ok) chk({tag, " accept timeout"}, 46'(ok), 46'd1);
  endtask

  task automatic send(input logic [12:0] s, input string tag);
    i_data.data = s;
    i_data.vld  = 1'b1;
    wait_acc(tag);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_tok(input string tag, input logic [45:0] exp);
    logic [45:0] obs;
    obs = 'x;
    if (got_q.size() > 0) obs = got_q.pop_front();
    chk(tag, obs, exp);
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, 46'(got_q.size()), 46'd0);
    got_q.delete();
  endtask

  initial begin
    rst         = 1'b1;
    i_data.data = 13'h0000;
    i_data.vld  = 1'b0;
    o_token.rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset vld",  46'(o_token.vld), 46'd0);
    chk("reset data", o_token.data,     46'd0);
    chk("reset rdy",  46'(i_data.rdy),  46'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: distinct literals then END marker
    watch_rdy = 1'b1;
    send(sb(8'h41), "t1 41");
    send(sb(8'h42), "t1 42");
    send(sb(8'h43), "t1 43");
    send(SYM_END,   "t1 end");
    settle();
    watch_rdy = 1'b0;
    chk("t1 rdy drops", 46'(rdy_drops), 46'd0);
    chk_tok("t1 lit41", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h41));
    chk_tok("t1 lit42", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h42));
    chk_tok("t1 lit43", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h43));
    chk_tok("t1 mark",  tk(2'd2, 16'd0, 16'd0, 4'h1, 8'h00));
    chk_empty("t1 extra");

    // 2: run of ten 61s, END flushes the match
    for (int i = 0; i < 10; i++) send(sb(8'h61), "t2 61");
    send(SYM_END, "t2 end");
    settle();
    chk_tok("t2 lit61", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h61));
    chk_tok("t2 copy",  tk(2'd1, 16'd0, 16'd8, 4'h0, 8'h00));
    chk_tok("t2 mark",  tk(2'd2, 16'd0, 16'd0, 4'h1, 8'h00));
    chk_empty("t2 extra");

    // 3: distance-2 match broken by 03
    send(sb(8'h01), "t3 a");
    send(sb(8'h02), "t3 b");
    send(sb(8'h01), "t3 c");
    send(sb(8'h02), "t3 d");
    send(sb(8'h01), "t3 e");
    send(sb(8'h02), "t3 f");
    send(sb(8'h03), "t3 g");
    settle();
    chk_tok("t3 lit01", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h01));
    chk_tok("t3 lit02", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h02));
    chk_tok("t3 copy",  tk(2'd1, 16'd1, 16'd3, 4'h0, 8'h00));
    chk_tok("t3 lit03", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h03));
    chk_empty("t3 extra");

    // 4: consumer stall holds token and blocks input
    o_token.rdy = 1'b0;
    send(sb(8'h10), "t4 10");
    i_data.data = sb(8'h11);
    i_data.vld  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4 held vld",  46'(o_token.vld), 46'd1);
      chk("t4 held data", o_token.data, tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h10));
      chk("t4 in rdy",    46'(i_data.rdy), 46'd0);
    end
    @(posedge clk);
    #1 o_token.rdy = 1'b1;
    wait_acc("t4 11");
    send(SYM_END, "t4 end");
    settle();
    chk_tok("t4 lit10", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h10));
    chk_tok("t4 lit11", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h11));
    chk_tok("t4 mark",  tk(2'd2, 16'd0, 16'd0, 4'h1, 8'h00));
    chk_empty("t4 extra");

    // 5: END clears history, so the trailing 00 is a literal
    send(sb(8'h00), "t5 a");
    send(sb(8'h00), "t5 b");
    send(sb(8'h00), "t5 c");
    send(SYM_END,   "t5 end");
    send(sb(8'h00), "t5 d");
    settle();
    chk_tok("t5 lit00",  tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h00));
    chk_tok("t5 copy",   tk(2'd1, 16'd0, 16'd1, 4'h0, 8'h00));
    chk_tok("t5 mark",   tk(2'd2, 16'd0, 16'd0, 4'h1, 8'h00));
    chk_tok("t5 lit00b", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h00));
    chk_empty("t5 extra");

    // 6: reset in the middle of a match drops it
    send(sb(8'h22), "t6 a");
    send(sb(8'h22), "t6 b");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6 rst vld", 46'(o_token.vld), 46'd0);
    chk("t6 rst rdy", 46'(i_data.rdy),  46'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_tok("t6 lit22 pre", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h22));
    chk_empty("t6 dropped");
    send(sb(8'h22), "t6 c");
    settle();
    chk_tok("t6 lit22 post", tk(2'd0, 16'd0, 16'd0, 4'h0, 8'h22));
    chk_empty("t6 extra");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
